pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard control unit for the 5-stage RISC-V pipeline, placed in ID between the IF/ID and ID/EX registers. Detects load-use hazards against the instruction in EX and holds PC and IF/ID for a configurable number of cycles while injecting bubbles into ID/EX. Also flushes on a taken branch/jump resolved in EX and on an external multi-cycle busy. An optional saturating counter tracks stall cycles.

## Interface
- REG_ADDR_W, 5: register-index width.
- LOAD_STALL, 1: bubbles inserted per load-use hazard (range 1..7).
- CNT_W, 16: stall-counter width (only with HAZARD_PERF_CNT_EN).

- clk  in  1  pipeline clock, all state on rising edge.
- arst_n  in  1  asynchronous active-low reset.
- rd_ex  in  REG_ADDR_W  destination register of the instruction in EX.
- mem_read_ex  in  1  instruction in EX is a load.
- rs1_id, rs2_id  in  REG_ADDR_W  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1  the ID instruction actually reads rs1/rs2.
- branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle.
- ex_busy  in  1  multi-cycle EX unit is not done; freeze the front end.
- pc_write  out  1  1 = PC may update.
- if_id_write  out  1  1 = IF/ID may load.
- mux_hazard_sel  out  1  1 = pass decoded control to ID/EX; 0 = insert bubble.
- if_id_flush, id_ex_flush  out  1  clear IF/ID, ID/EX on the next edge.
- stall_active  out  1  load-use stall in progress (detect cycle or held cycles).
- stall_cnt  out  CNT_W  stall cycles counted (only with HAZARD_PERF_CNT_EN).

## Operation
- Hazard: mem_read_ex && rd_ex != 0 && ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex)). x0 never causes a stall.
- FSM states: IDLE, HOLD.
- IDLE, hazard, no branch: pc_write=0, if_id_write=0, mux_hazard_sel=0, stall_active=1. If LOAD_STALL > 1, load remaining counter with LOAD_STALL-1 and go to HOLD. Otherwise stay in IDLE.
- HOLD: same stall outputs regardless of inputs; decrement counter each cycle; return to IDLE when the counter reaches 0 at the edge. Total stall = LOAD_STALL cycles.
- A new hazard detected in IDLE on the cycle right after HOLD ends is handled as a fresh hazard.
- branch_taken_ex (highest priority, any state):
  - if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, mux_hazard_sel=0.
  - FSM forced to IDLE and counter cleared.
  - stall_active=0.
- ex_busy (priority below branch, above hazard):
  - pc_write=0, if_id_write=0, mux_hazard_sel=1, no flush, stall_active=0.
  - FSM and counter frozen.
  - A hazard seen during ex_busy is not latched; it is re-evaluated after busy drops.
- Otherwise, default outputs: pc_write=1, if_id_write=1, mux_hazard_sel=1, flushes 0.

## Timing
- Outputs are combinational from inputs plus registered FSM/counter. The detect cycle stalls in the same cycle as the hazard appears (zero latency).
- Reset values (asynchronous, while arst_n=0): FSM=IDLE, counter=0, stall_cnt=0. With all inputs 0, outputs are pc_write=1, if_id_write=1, mux_hazard_sel=1, flushes=0, stall_active=0.
- Reset mid-HOLD aborts the stall immediately; the first edge after release starts in IDLE.
- The HOLD counter is 3 bits; LOAD_STALL outside 1..7 is illegal (elaboration-time check with $error).

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt port exists.
  - It increments by 1 on every edge where stall_active=1 or ex_busy=1 (branch not taken).
  - It saturates at all-ones; reset only by arst_n.
- HAZARD_PERF_CNT_EN undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset then idle: arst_n=0→1, inputs 0 → pc_write=1, if_id_write=1, mux_hazard_sel=1, flushes 0.
- LOAD_STALL=1: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle → exactly 1 cycle of pc_write=0, mux_hazard_sel=0, then defaults. Same with rd_ex=0 → no stall. Same with rs1_used_id=0 → no stall.
- LOAD_STALL=3: hazard for one cycle, then mem_read_ex=0 → stall_active=1 for exactly 3 cycles; with HAZARD_PERF_CNT_EN, stall_cnt=3 afterwards.
- LOAD_STALL=3: branch_taken_ex=1 in the second stall cycle → if_id_flush=id_ex_flush=1, pc_write=1 that cycle; FSM back in IDLE; no third stall cycle.
- ex_busy=1 for 4 cycles during HOLD with 2 cycles left → front frozen, counter unchanged; after busy drops, 2 more stall cycles follow.
- CNT_W=4, HAZARD_PERF_CNT_EN: 20 consecutive ex_busy cycles → stall_cnt saturates at 15. Assert arst_n mid-HOLD → outputs return to defaults without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: ID-stage load-use stall, branch flush and busy-freeze control.
// Optional saturating stall-cycle counter (stall_cnt) exists only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic                  branch_taken_ex,
  input  logic                  ex_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  mux_hazard_sel,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [2:0] HOLD_INIT = 3'(LOAD_STALL - 1);
  if (LOAD_STALL < 1 || LOAD_STALL > 7) begin : g_bad_load_stall
    $error("pipeline_hazard_ctrl: LOAD_STALL must be in 1..7");
  end
  state_t state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic hazard;
  always_comb begin
    hazard = mem_read_ex && (rd_ex != '0) &&
             ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
    stall_active = !branch_taken_ex && !ex_busy && (state == HOLD || hazard);
    pc_write = branch_taken_ex || !(ex_busy || stall_active);
    if_id_write = pc_write;
    mux_hazard_sel = !branch_taken_ex && !stall_active;
    if_id_flush = branch_taken_ex;
    id_ex_flush = branch_taken_ex;
  end
  // Branch wins over everything; busy freezes the FSM so the remaining hold count survives.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (branch_taken_ex) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (!ex_busy) begin
      if (state == HOLD) begin
        cnt_nxt = cnt - 3'd1;
        state_nxt = (cnt == 3'd1) ? IDLE : HOLD;
      end else if (hazard && LOAD_STALL > 1) begin
        cnt_nxt = HOLD_INIT;
        state_nxt = HOLD;
      end
    end
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)
      stall_cnt <= '0;
    else if ((stall_active || (ex_busy && !branch_taken_ex)) && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of two instances (LOAD_STALL=1 and LOAD_STALL=3, CNT_W=4).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic arst_n;
  logic [4:0] rd_ex, rs1_id, rs2_id;
  logic mem_read_ex, rs1_used_id, rs2_used_id, branch_taken_ex, ex_busy;
  logic pc_write1, if_id_write1, mux1, if_flush1, ex_flush1, stall1;
  logic pc_write3, if_id_write3, mux3, if_flush3, ex_flush3, stall3;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] cnt1;
  logic [3:0]  cnt3;
`endif
  int checks = 0;
  int errors = 0;
  localparam logic [5:0] DEF = 6'b111000;
  localparam logic [5:0] STL = 6'b000001;
  localparam logic [5:0] BSY = 6'b001000;
  localparam logic [5:0] BR  = 6'b110110;
  wire [5:0] o1 = {pc_write1, if_id_write1, mux1, if_flush1, ex_flush1, stall1};
  wire [5:0] o3 = {pc_write3, if_id_write3, mux3, if_flush3, ex_flush3, stall3};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(1)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(16)
`endif
  ) u1 (
    .clk(clk), .arst_n(arst_n), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .branch_taken_ex(branch_taken_ex), .ex_busy(ex_busy),
    .pc_write(pc_write1), .if_id_write(if_id_write1), .mux_hazard_sel(mux1),
    .if_id_flush(if_flush1), .id_ex_flush(ex_flush1), .stall_active(stall1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(cnt1)
`endif
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .LOAD_STALL(3)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) u3 (
    .clk(clk), .arst_n(arst_n), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .branch_taken_ex(branch_taken_ex), .ex_busy(ex_busy),
    .pc_write(pc_write3), .if_id_write(if_id_write3), .mux_hazard_sel(mux3),
    .if_id_flush(if_flush3), .id_ex_flush(ex_flush3), .stall_active(stall3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(cnt3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int e1, input int e3);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "_cnt1"}, 32'(cnt1), 32'(e1));
    chk({tag, "_cnt3"}, 32'(cnt3), 32'(e3));
`else
    if (e1 < 0 || e3 < 0) $display("unexpected %s", tag);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_n = 1'b0;
    {rd_ex, rs1_id, rs2_id} = '0;
    {mem_read_ex, rs1_used_id, rs2_used_id, branch_taken_ex, ex_busy} = '0;
    #2;
    chk("reset_u1", o1, DEF);
    chk("reset_u3", o3, DEF);
    chk_cnt("reset", 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    tick;
    chk("idle", o3, DEF);
    mem_read_ex = 1; rd_ex = 5; rs1_id = 5; rs1_used_id = 1; #1;
    chk("ls1_detect", o1, STL);
    chk("ls3_detect", o3, STL);
    tick;
    mem_read_ex = 0; rs1_used_id = 0; #1;
    chk("ls1_release", o1, DEF);
    chk("ls3_hold1", o3, STL);
    tick;
    chk("ls3_hold2", o3, STL);
    tick;
    chk("ls3_done", o3, DEF);
    chk_cnt("ls", 1, 3);
    mem_read_ex = 1; rd_ex = 0; rs1_id = 0; rs1_used_id = 1; #1;
    chk("x0_u1", o1, DEF);
    chk("x0_u3", o3, DEF);
    tick;
    rd_ex = 5; rs1_id = 5; rs1_used_id = 0; rs2_id = 7; rs2_used_id = 1; #1;
    chk("rs1_unused", o1, DEF);
    tick;
    rs2_id = 5; #1;
    chk("rs2_hazard_u1", o1, STL);
    chk("rs2_hazard_u3", o3, STL);
    tick;
    mem_read_ex = 0; rs2_used_id = 0; branch_taken_ex = 1; #1;
    chk("branch_flush", o3, BR);
    tick;
    branch_taken_ex = 0; #1;
    chk("post_branch", o3, DEF);
    chk_cnt("branch", 2, 4);
    mem_read_ex = 1; rs1_used_id = 1; #1;
    chk("busy_detect", o3, STL);
    tick;
    mem_read_ex = 0; rs1_used_id = 0; ex_busy = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("busy_freeze", o3, BSY);
      tick;
    end
    ex_busy = 0; #1;
    chk("busy_hold1", o3, STL);
    tick;
    chk("busy_hold2", o3, STL);
    tick;
    chk("busy_done", o3, DEF);
    chk_cnt("busy", 7, 11);
    ex_busy = 1;
    repeat (20) tick;
    ex_busy = 0; #1;
    chk_cnt("saturate", 27, 15);
    mem_read_ex = 1; rs1_used_id = 1; #1;
    chk("b2b_detect", o3, STL);
    tick;
    mem_read_ex = 0; #1;
    chk("b2b_hold1", o3, STL);
    tick;
    chk("b2b_hold2", o3, STL);
    tick;
    mem_read_ex = 1; #1;
    chk("fresh_hazard", o3, STL);
    tick;
    mem_read_ex = 0; #1;
    chk("fresh_hold", o3, STL);
    arst_n = 1'b0; #1;
    chk("async_reset", o3, DEF);
    chk_cnt("async_reset", 0, 0);
    @(negedge clk);
    arst_n = 1'b1;
    tick;
    chk("after_reset", o3, DEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
